cordic_pipeline_hs: RTL and testbench

- Parametrised, flow-controlled CORDIC pipeline. Successor to the fixed 6-stage rotation-only core.
- Each sample independently selects rotation mode (rotate vector (x,y) by an angle) or vectoring mode (magnitude and phase of (x,y)).
- Full-range quadrant handling, K-gain compensation, output saturation and valid/ready backpressure.
- Sits between the sample source and downstream DSP as a drop-in streaming core.

---
 rtl/cordic_pipeline_hs.sv | 181 ++++++++++++++++++
 tb/tb_cordic_pipeline_hs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipeline_hs.sv
// Streaming CORDIC core: each sample picks rotation or vectoring mode. It has
// quadrant pre-rotation, gain compensation and saturation, and one global stall.
module cordic_pipeline_hs #(
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_FRAC        = 8,
  parameter int ANGLE_WIDTH      = 16,
  parameter int ANGLE_FRAC       = 7,
  parameter int ITERATION_NUMBER = 16,
  parameter int ITER_WIDTH       = 32,
  parameter int ITER_FRAC        = 20,
  parameter int K_Q16            = 39797
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic signed [DATA_WIDTH-1:0]  in_x,
  input  logic signed [DATA_WIDTH-1:0]  in_y,
  input  logic signed [ANGLE_WIDTH-1:0] in_angle,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_mode,
  output logic signed [DATA_WIDTH-1:0]  out_x,
  output logic signed [DATA_WIDTH-1:0]  out_y,
  output logic signed [ANGLE_WIDTH-1:0] out_angle,
  output logic                          out_sat
);
  localparam int N          = ITERATION_NUMBER;
  localparam int W          = ITER_WIDTH;
  localparam int PW         = ITER_WIDTH + 18;
  localparam int XY_SHIFT   = ITER_FRAC - DATA_FRAC;
  localparam int Z_SHIFT    = ITER_FRAC - ANGLE_FRAC;
  localparam int POST_SHIFT = ITER_FRAC + 16 - DATA_FRAC;
  localparam int ATAN_FRAC  = 20;
  localparam int ATAN_UP    = (ITER_FRAC >= ATAN_FRAC) ? ITER_FRAC - ATAN_FRAC : 0;
  localparam int ATAN_DN    = (ITER_FRAC < ATAN_FRAC) ? ATAN_FRAC - ITER_FRAC : 0;

  localparam logic signed [W-1:0]  DEG90  = W'(longint'(90) <<< ITER_FRAC);
  localparam logic signed [W-1:0]  DEG180 = W'(longint'(180) <<< ITER_FRAC);
  localparam logic signed [W-1:0]  Z_RND  = W'(longint'(1) <<< (Z_SHIFT - 1));
  localparam logic signed [PW-1:0] K_MUL  = PW'(longint'(K_Q16));
  localparam logic signed [PW-1:0] P_RND  = PW'(longint'(1) <<< (POST_SHIFT - 1));
  localparam logic signed [PW-1:0] O_MAX  = PW'((longint'(1) <<< (DATA_WIDTH - 1)) - longint'(1));
  localparam logic signed [PW-1:0] O_MIN  = PW'(-(longint'(1) <<< (DATA_WIDTH - 1)));

  // atan(2^-i) in degrees with 20 fractional bits, rescaled to the internal format
  function automatic logic signed [W-1:0] atan_entry(input int i);
    longint v;
    case (i)
      0: v = 47185920;   1: v = 27855475;   2: v = 14718068;   3: v = 7471121;
      4: v = 3750058;    5: v = 1876857;    6: v = 938658;     7: v = 469357;
      8: v = 234682;     9: v = 117342;    10: v = 58671;     11: v = 29335;
      12: v = 14668;    13: v = 7334;      14: v = 3667;      15: v = 1833;
      16: v = 917;      17: v = 458;       18: v = 229;       19: v = 115;
      20: v = 57;       21: v = 29;        22: v = 14;        23: v = 7;
      default: v = 0;
    endcase
    return W'(((v <<< ATAN_UP) + ((longint'(1) <<< ATAN_DN) >>> 1)) >>> ATAN_DN);
  endfunction

  logic                en;
  logic [N:0]          valid_reg, mode_reg, zero_reg;
  logic signed [W-1:0] x_reg [0:N];
  logic signed [W-1:0] y_reg [0:N];
  logic signed [W-1:0] z_reg [0:N];
  logic signed [W-1:0] x_next [1:N];
  logic signed [W-1:0] y_next [1:N];
  logic signed [W-1:0] z_next [1:N];
  logic signed [W-1:0] ext_x, ext_y, ext_z, pre_x, pre_y, pre_z;
  logic                pre_zero;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign ext_x = {{(W-DATA_WIDTH){in_x[DATA_WIDTH-1]}}, in_x} <<< XY_SHIFT;
  assign ext_y = {{(W-DATA_WIDTH){in_y[DATA_WIDTH-1]}}, in_y} <<< XY_SHIFT;
  assign ext_z = {{(W-ANGLE_WIDTH){in_angle[ANGLE_WIDTH-1]}}, in_angle} <<< Z_SHIFT;

  // Fold the input into the +-90 degree convergence range with a 180 degree turn
  always_comb begin
    pre_x    = ext_x;
    pre_y    = ext_y;
    pre_z    = ext_z;
    pre_zero = 1'b0;
    if (!in_mode) begin
      if (ext_z > DEG90) begin
        pre_x = -ext_x;  pre_y = -ext_y;  pre_z = ext_z - DEG180;
      end else if (ext_z < -DEG90) begin
        pre_x = -ext_x;  pre_y = -ext_y;  pre_z = ext_z + DEG180;
      end
    end else begin
      pre_z    = '0;
      // a zero vector has no phase; the flag forces the reported angle to 0
      pre_zero = (ext_x == '0) && (ext_y == '0);
      if (ext_x[W-1]) begin
        pre_x = -ext_x;
        pre_y = -ext_y;
        pre_z = ext_y[W-1] ? -DEG180 : DEG180;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_iter
      localparam logic signed [W-1:0] ATAN = atan_entry(gi);
      logic d_pos;
      assign d_pos = mode_reg[gi] ? y_reg[gi][W-1] : !z_reg[gi][W-1];
      assign x_next[gi+1] = d_pos ? x_reg[gi] - (y_reg[gi] >>> gi) : x_reg[gi] + (y_reg[gi] >>> gi);
      assign y_next[gi+1] = d_pos ? y_reg[gi] + (x_reg[gi] >>> gi) : y_reg[gi] - (x_reg[gi] >>> gi);
      assign z_next[gi+1] = d_pos ? z_reg[gi] - ATAN : z_reg[gi] + ATAN;
    end
  endgenerate

  logic signed [PW-1:0]         prod_x, prod_y, rnd_x, rnd_y;
  logic signed [W-1:0]          rnd_z;
  logic signed [DATA_WIDTH-1:0] post_x, post_y;
  logic signed [ANGLE_WIDTH-1:0] post_z;
  logic                         post_sat;

  assign prod_x = PW'(x_reg[N]) * K_MUL;
  assign prod_y = PW'(y_reg[N]) * K_MUL;
  assign rnd_x  = (prod_x + P_RND) >>> POST_SHIFT;
  assign rnd_y  = (prod_y + P_RND) >>> POST_SHIFT;
  assign rnd_z  = (z_reg[N] + Z_RND) >>> Z_SHIFT;

  always_comb begin
    post_x   = DATA_WIDTH'(rnd_x);
    post_y   = DATA_WIDTH'(rnd_y);
    post_sat = 1'b0;
    if (rnd_x > O_MAX) begin
      post_x = DATA_WIDTH'(O_MAX);  post_sat = 1'b1;
    end else if (rnd_x < O_MIN) begin
      post_x = DATA_WIDTH'(O_MIN);  post_sat = 1'b1;
    end
    if (rnd_y > O_MAX) begin
      post_y = DATA_WIDTH'(O_MAX);  post_sat = 1'b1;
    end else if (rnd_y < O_MIN) begin
      post_y = DATA_WIDTH'(O_MIN);  post_sat = 1'b1;
    end
    post_z = zero_reg[N] ? '0 : ANGLE_WIDTH'(rnd_z);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      mode_reg  <= '0;
      zero_reg  <= '0;
      for (int i = 0; i <= N; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
        z_reg[i] <= '0;
      end
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      valid_reg <= {valid_reg[N-1:0], in_valid};
      mode_reg  <= {mode_reg[N-1:0], in_mode};
      zero_reg  <= {zero_reg[N-1:0], pre_zero};
      x_reg[0]  <= pre_x;
      y_reg[0]  <= pre_y;
      z_reg[0]  <= pre_z;
      for (int i = 1; i <= N; i++) begin
        x_reg[i] <= x_next[i];
        y_reg[i] <= y_next[i];
        z_reg[i] <= z_next[i];
      end
      out_valid <= valid_reg[N];
      out_mode  <= mode_reg[N];
      out_x     <= post_x;
      out_y     <= post_y;
      out_angle <= post_z;
      out_sat   <= post_sat;
    end
  end
endmodule

// File: tb/tb_cordic_pipeline_hs.sv
// Scoreboard bench for cordic_pipeline_hs: expectations come from directed constants
// or a real-arithmetic trigonometric model; a separate monitor pops and compares.
module tb_cordic_pipeline_hs;
  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_mode = 1'b0;
  logic signed [15:0] in_x = '0, in_y = '0, in_angle = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_mode;
  logic signed [15:0] out_x, out_y, out_angle;
  logic               out_sat;

  cordic_pipeline_hs dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_x(out_x), .out_y(out_y), .out_angle(out_angle), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode; bit chk; bit wrap; bit sat;
    int ex; int ey; int ea; int tx; int ty; int ta;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail = 0;
  int   seq = 0;
  int   ready_mode = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic cmp(input string name, input int idx, input int act, input int req, input int tol);
    n_checks++;
    if (iabs(act - req) > tol) begin
      n_fail++;
      $display("FAIL %s (result %0d): got %0d, required %0d +/- %0d", name, idx, act, req, tol);
    end
  endtask

  task automatic cmp_ang(input int idx, input int act, input int req, input int tol, input bit wrap);
    int d;
    d = act - req;
    if (wrap && d > 23040) d -= 46080;
    if (wrap && d < -23040) d += 46080;
    n_checks++;
    if (iabs(d) > tol) begin
      n_fail++;
      $display("FAIL out_angle (result %0d): got %0d, required %0d +/- %0d", idx, act, req, tol);
    end
  endtask

  function automatic exp_t mk(input bit m, input int ex, input int ey, input int ea, input bit sat,
                              input int tx, input int ty, input int ta);
    exp_t e;
    e.mode = m; e.chk = 1'b1; e.wrap = 1'b0; e.sat = sat;
    e.ex = ex; e.ey = ey; e.ea = ea; e.tx = tx; e.ty = ty; e.ta = ta;
    return e;
  endfunction

  function automatic int to_lsb(input real v, input real scale);
    return $rtoi($floor(v * scale + 0.5));
  endfunction

  // Ideal result: plain rotation by the angle, or magnitude and atan2 phase
  function automatic exp_t model(input bit m, input int x, input int y, input int a);
    real xr, yr, th, rx, ry, ra;
    exp_t e;
    xr = x / 256.0;
    yr = y / 256.0;
    if (!m) begin
      th = (a / 128.0) * PI / 180.0;
      rx = xr * $cos(th) - yr * $sin(th);
      ry = xr * $sin(th) + yr * $cos(th);
      ra = 0.0;
    end else begin
      rx = $sqrt(xr * xr + yr * yr);
      ry = 0.0;
      ra = (x == 0 && y == 0) ? 0.0 : $atan2(yr, xr) * 180.0 / PI;
    end
    e = mk(m, to_lsb(rx, 256.0), to_lsb(ry, 256.0), to_lsb(ra, 128.0), 1'b0, 2, 2, 2);
    e.wrap = 1'b1;
    return e;
  endfunction

  // Monitor: consumes results whenever a transfer happens on the output side
  always @(negedge clk) begin
    if (reset) begin
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready: got %b, required %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got x=%0d y=%0d angle=%0d, required no result", out_x, out_y, out_angle);
        end else begin
          e_mon = sb.pop_front();
          cmp("out_mode", seq, int'(out_mode), int'(e_mon.mode), 0);
          if (e_mon.chk) begin
            cmp("out_x", seq, int'(out_x), e_mon.ex, e_mon.tx);
            cmp("out_y", seq, int'(out_y), e_mon.ey, e_mon.ty);
            cmp_ang(seq, int'(out_angle), e_mon.ea, e_mon.ta, e_mon.wrap);
            cmp("out_sat", seq, int'(out_sat), int'(e_mon.sat), 0);
          end
          seq++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted it
  task automatic send(input bit m, input int x, input int y, input int a, input exp_t e);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_mode = m;
    in_x = 16'(x); in_y = 16'(y); in_angle = 16'(a);
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: got no in_ready in %0d cycles, required acceptance", waited);
          break;
        end
      end
    end
    if (acc) sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    cmp("drain_outstanding", -1, sb.size(), 0, 0);
  endtask

  exp_t ed;
  int   lat, x, y, a;
  bit   m;

  initial begin
    repeat (3) @(negedge clk);
    cmp("reset_out_valid", -1, int'(out_valid), 0, 0);
    cmp("reset_out_x", -1, int'(out_x), 0, 0);
    cmp("reset_out_y", -1, int'(out_y), 0, 0);
    cmp("reset_out_angle", -1, int'(out_angle), 0, 0);
    cmp("reset_out_mode", -1, int'(out_mode), 0, 0);
    cmp("reset_out_sat", -1, int'(out_sat), 0, 0);
    reset = 1'b1;
    #1;
    cmp("reset_in_ready", -1, int'(in_ready), 1, 0);
    idle(2);

    // Rotation by 30 degrees, measuring latency on an empty pipeline
    send(1'b0, 256, 0, 3840, mk(1'b0, 222, 128, 0, 1'b0, 1, 1, 1));
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    cmp("latency", -1, lat, 18, 0);
    idle(1);

    send(1'b1, 768, 1024, 0, mk(1'b1, 1280, 0, 6801, 1'b0, 1, 1, 2));
    send(1'b1, -256, 0, 0, mk(1'b1, 256, 0, 23040, 1'b0, 1, 1, 1));
    send(1'b0, 256, 0, 19200, mk(1'b0, -222, 128, 0, 1'b0, 1, 1, 1));
    send(1'b0, 256, 0, -19200, mk(1'b0, -222, -128, 0, 1'b0, 1, 1, 1));
    send(1'b1, 0, 0, 0, mk(1'b1, 0, 0, 0, 1'b0, 0, 0, 0));
    send(1'b0, 256, 0, 11520, mk(1'b0, 0, 256, 0, 1'b0, 1, 1, 1));
    send(1'b0, 256, 0, -11520, mk(1'b0, 0, -256, 0, 1'b0, 1, 1, 1));
    send(1'b1, 32512, 32512, 0, mk(1'b1, 32767, 0, 5760, 1'b1, 0, 1, 1));
    send(1'b0, 256, 0, 3840, mk(1'b0, 222, 128, 0, 1'b0, 1, 1, 1));
    ed = mk(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    ed.chk = 1'b0;
    send(1'b0, 256, 0, 25600, ed);
    send(1'b1, 768, 1024, 0, mk(1'b1, 1280, 0, 6801, 1'b0, 1, 1, 2));
    drain();

    // Random mixed-mode stream under 50% output backpressure
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(0, 1));
      do begin
        x = int'($urandom_range(0, 40960)) - 20480;
        y = int'($urandom_range(0, 40960)) - 20480;
      end while (m && (iabs(x) + iabs(y) < 1024));
      a = int'($urandom_range(0, 46080)) - 23040;
      send(m, x, y, a, model(m, x, y, a));
    end
    drain();

    // Asynchronous reset with samples stalled in flight
    ready_mode = 2;
    idle(2);
    for (int k = 0; k < 10; k++) begin
      x = int'($urandom_range(0, 40960)) - 20480;
      y = int'($urandom_range(0, 40960)) - 20480;
      send(1'b0, x, y, 0, model(1'b0, x, y, 0));
    end
    idle(25);
    cmp("stalled_out_valid", -1, int'(out_valid), 1, 0);
    #2;
    reset = 1'b0;
    #1;
    cmp("async_reset_out_valid", -1, int'(out_valid), 0, 0);
    cmp("async_reset_out_x", -1, int'(out_x), 0, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    ready_mode = 1;
    repeat (30) begin
      @(negedge clk);
      cmp("post_reset_out_valid", -1, int'(out_valid), 0, 0);
    end
    idle(1);
    ready_mode = 0;
    send(1'b0, 256, 0, 3840, mk(1'b0, 222, 128, 0, 1'b0, 1, 1, 1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
